// File: rtl/usart_tx.sv
// usart_tx
// Serial transmitter of the USART. Drains a show-ahead 8-bit TX FIFO and sends
// each byte as an asynchronous frame:
//   start bit (0), 8 data bits LSB first, optional parity bit, 1 or 2 stop bits (1).
// Frames run back to back with no idle gap while tx_en is high and the FIFO has data.
//
// Compile-time option:
//   USART_TX_PARITY_EN  -- when defined, a parity bit follows the data bits
//                          (even parity for PARITY_ODD = 0, odd for PARITY_ODD = 1).
//                          When undefined there is no parity state or logic and
//                          PARITY_ODD has no effect.
module usart_tx #(
    parameter int unsigned BAUD_DIV   = 868,  // CPU_Clk cycles per serial bit, 2..65535
    parameter int unsigned STOP_BITS  = 1,    // 1 or 2
    parameter int unsigned PARITY_ODD = 0     // 0 = even, 1 = odd
) (
    input  logic       CPU_Clk,
    input  logic       Reset_n,
    input  logic       tx_en,
    input  logic [7:0] fifo_data,
    input  logic       fifo_empty,
    output logic       fifo_rd,
    output logic       Tx,
    output logic       busy,
    output logic       tx_done
);

    // ------------------------------------------------------------------
    // Parameter legality
    // ------------------------------------------------------------------
    if (BAUD_DIV < 2 || BAUD_DIV > 65535 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD > 1) begin : g_bad_params
        $error("usart_tx: unsupported BAUD_DIV / STOP_BITS / PARITY_ODD setting");
    end

    // ------------------------------------------------------------------
    // Local constants and types
    // ------------------------------------------------------------------
    localparam int unsigned      CNT_W     = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    // Index of the final stop bit in the bit counter (0 for one stop bit, 1 for two).
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef USART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e           state_q,    state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_cnt_q,  bit_cnt_d;
    logic [7:0]       shift_q,    shift_d;
    logic             tx_q,       tx_d;
`ifdef USART_TX_PARITY_EN
    logic             par_q,      par_d;
`endif

    // ------------------------------------------------------------------
    // Decodes shared by next-state logic and outputs
    // ------------------------------------------------------------------
    logic bit_tick;   // last clock of the current serial bit
    logic last_stop;  // bit counter points at the final stop bit
    logic frame_end;  // last clock of the final stop bit
    logic load;       // pop the FIFO head and start a new frame on the next edge

    assign bit_tick  = (baud_cnt_q == BAUD_LAST);
    assign last_stop = (bit_cnt_q == STOP_LAST);
    assign frame_end = (state_q == ST_STOP) && last_stop && bit_tick;
    assign load      = tx_en && !fifo_empty && ((state_q == ST_IDLE) || frame_end);

    assign fifo_rd = load;
    assign tx_done = frame_end;
    assign busy    = (state_q != ST_IDLE);
    assign Tx      = tx_q;

    // Next-state logic: bit timing, frame sequencing and the next serial line level.
    // NOTE: every variable is given a default before the case so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
`ifdef USART_TX_PARITY_EN
        par_d      = par_q;
`endif

        // Baud counter free-runs through a frame and wraps at the end of each bit.
        if (state_q != ST_IDLE) begin
            baud_cnt_d = bit_tick ? '0 : baud_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                // Waits for load, handled below.
            end
            ST_START: begin
                if (bit_tick) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;  // wraps to 0 after bit 7
                    if (bit_cnt_q == 3'd7) begin
`ifdef USART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef USART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_tick) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_tick) begin
                    if (last_stop) begin
                        state_d   = ST_IDLE;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new frame (from idle or straight out of the final stop bit) overrides
        // the sequencing above and restarts all bit timing.
        if (load) begin
            state_d    = ST_START;
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
            shift_d    = fifo_data;
`ifdef USART_TX_PARITY_EN
            par_d      = (PARITY_ODD != 0) ? ~^fifo_data : ^fifo_data;
`endif
        end

        // The line level is computed from the next state so the registered Tx
        // changes on the same edge as the state.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef USART_TX_PARITY_EN
            ST_PARITY: tx_d = par_d;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    // State register; reset returns the line to idle-high immediately.
    // NOTE: flops are written with non-blocking assignments so each one samples pre-edge values.
    always_ff @(posedge CPU_Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
`ifdef USART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
`ifdef USART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_usart_tx.sv
// tb_usart_tx
// Scoreboard bench for usart_tx. Two instances share clock, reset and tx_en:
//   ch0: BAUD_DIV = 4, STOP_BITS = 1, PARITY_ODD = 0
//   ch1: BAUD_DIV = 4, STOP_BITS = 2, PARITY_ODD = 1
// Each has its own show-ahead FIFO model. Stimulus pushes bytes into a FIFO and,
// when a frame is expected, into that channel's expected queue; a per-channel
// monitor decodes every frame seen on Tx and compares it against the queue head.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_usart_tx;

    localparam int BAUD = 4;
`ifdef USART_TX_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif

    logic       CPU_Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       tx_en   = 1'b0;
    logic [1:0] fifo_empty = 2'b11;
    logic [7:0] fifo_data [2];
    logic [1:0] rd, tx, busy, done;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   rd_cnt [2] = '{0, 0};
    bit   mon_en = 1'b1;

    logic [7:0] fq0 [$];
    logic [7:0] fq1 [$];
    logic [7:0] exp0 [$];
    logic [7:0] exp1 [$];
    int         start_log [$];

    always #5 CPU_Clk = ~CPU_Clk;

    usart_tx #(.BAUD_DIV(BAUD), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
        .CPU_Clk   (CPU_Clk),
        .Reset_n   (Reset_n),
        .tx_en     (tx_en),
        .fifo_data (fifo_data[0]),
        .fifo_empty(fifo_empty[0]),
        .fifo_rd   (rd[0]),
        .Tx        (tx[0]),
        .busy      (busy[0]),
        .tx_done   (done[0])
    );

    usart_tx #(.BAUD_DIV(BAUD), .STOP_BITS(2), .PARITY_ODD(1)) dut1 (
        .CPU_Clk   (CPU_Clk),
        .Reset_n   (Reset_n),
        .tx_en     (tx_en),
        .fifo_data (fifo_data[1]),
        .fifo_empty(fifo_empty[1]),
        .fifo_rd   (rd[1]),
        .Tx        (tx[1]),
        .busy      (busy[1]),
        .tx_done   (done[1])
    );

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic push(input int ch, input logic [7:0] b, input bit expect_frame);
        if (ch == 0) begin
            fq0.push_back(b);
            if (expect_frame) exp0.push_back(b);
        end else begin
            fq1.push_back(b);
            if (expect_frame) exp1.push_back(b);
        end
    endtask

    function automatic bit exp_pop(input int ch, output logic [7:0] b);
        b = 8'h00;
        if (ch == 0) begin
            if (exp0.size() == 0) return 1'b0;
            b = exp0.pop_front();
        end else begin
            if (exp1.size() == 0) return 1'b0;
            b = exp1.pop_front();
        end
        return 1'b1;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge CPU_Clk);
    endtask

    task automatic drive_slot();
        @(posedge CPU_Clk);
        #1;
    endtask

    // Waits (bounded) for fifo_rd or tx_done of a channel; returns the cycle or -1.
    task automatic wait_for(input int ch, input bit want_done, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge CPU_Clk);
            if ((want_done ? done[ch] : rd[ch]) === 1'b1) begin
                at = cyc;
                break;
            end
        end
        check($sformatf("ch%0d wait %s", ch, want_done ? "tx_done" : "fifo_rd"), 32'(at >= 0), 1);
    endtask

    // ------------------------------------------------------------------
    // FIFO models (show-ahead) and cycle counter
    // ------------------------------------------------------------------
    always @(posedge CPU_Clk) begin
        cyc++;
        if (rd[0] && fq0.size() > 0) void'(fq0.pop_front());
        if (rd[1] && fq1.size() > 0) void'(fq1.pop_front());
        fifo_empty[0] <= (fq0.size() == 0);
        fifo_empty[1] <= (fq1.size() == 0);
        fifo_data[0]  <= (fq0.size() > 0) ? fq0[0] : 8'h00;
        fifo_data[1]  <= (fq1.size() > 0) ? fq1[0] : 8'h00;
    end

    // Pop-strobe bookkeeping and the never-pop-when-empty rule.
    always @(negedge CPU_Clk) begin
        for (int ch = 0; ch < 2; ch++) begin
            if (rd[ch] === 1'b1) rd_cnt[ch]++;
            if (rd[ch] === 1'b1 && fifo_empty[ch] === 1'b1) begin
                tests++;
                fails++;
                $display("FAIL ch%0d fifo_rd_while_empty: fifo_rd=1, required 0 (t=%0t)", ch, $time);
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame monitor: decodes one frame per start bit and scores it.
    // ------------------------------------------------------------------
    task automatic monitor(input int ch);
        int         nb;
        logic [7:0] d;
        logic [7:0] e;
        logic       p;
        logic       v;
        bit         have, stable_ok, busy_ok, done_ok, stop_ok;
        nb = 9 + PAR_EN + ((ch == 0) ? 1 : 2);
        forever begin
            @(negedge CPU_Clk);
            if (mon_en && Reset_n && tx[ch] === 1'b0) begin
                if (ch == 0) start_log.push_back(cyc);
                stable_ok = 1'b1; busy_ok = 1'b1; done_ok = 1'b1; stop_ok = 1'b1;
                d = 8'h00; p = 1'b0; v = 1'b0;
                for (int b = 0; b < nb; b++) begin
                    for (int c = 0; c < BAUD; c++) begin
                        if (b != 0 || c != 0) @(negedge CPU_Clk);
                        if (c == 0) v = tx[ch];
                        else if (tx[ch] !== v) stable_ok = 1'b0;
                        if (busy[ch] !== 1'b1) busy_ok = 1'b0;
                        if (done[ch] !== ((b == nb - 1 && c == BAUD - 1) ? 1'b1 : 1'b0)) done_ok = 1'b0;
                    end
                    if (b >= 1 && b <= 8) d[b-1] = v;
                    else if (b >= 9 + PAR_EN && v !== 1'b1) stop_ok = 1'b0;
`ifdef USART_TX_PARITY_EN
                    if (b == 9) p = v;
`endif
                end
                have = exp_pop(ch, e);
                check($sformatf("ch%0d frame expected", ch), 32'(have), 1);
                if (have) begin
                    check($sformatf("ch%0d data", ch), 32'(d), 32'(e));
`ifdef USART_TX_PARITY_EN
                    check($sformatf("ch%0d parity of %02h", ch, e), 32'(p),
                          32'((ch == 0) ? ^e : ~^e));
`endif
                end
                check($sformatf("ch%0d bit width stable", ch), 32'(stable_ok), 1);
                check($sformatf("ch%0d busy in frame", ch), 32'(busy_ok), 1);
                check($sformatf("ch%0d tx_done position", ch), 32'(done_ok), 1);
                check($sformatf("ch%0d stop bits high", ch), 32'(stop_ok), 1);
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        int r, d1, d2, nb0, nb1, base, gap;
        bit seen_rd, seen_low, seen_busy, seen_done;
        nb0 = 10 + PAR_EN;
        nb1 = 11 + PAR_EN;

        // Reset values
        cycles(3);
        check("reset Tx", 32'(tx), 32'(2'b11));
        check("reset busy", 32'(busy), 0);
        check("reset tx_done", 32'(done), 0);
        check("reset fifo_rd", 32'(rd), 0);
        drive_slot();
        Reset_n = 1'b1;

        // Single frame 0xA5 on ch0
        drive_slot();
        tx_en = 1'b1;
        push(0, 8'hA5, 1'b1);
        wait_for(0, 1'b0, 10, r);
        wait_for(0, 1'b1, 80, d1);
        check("t1 tx_done cycle after pop", 32'(d1 - r), 32'(4 * nb0));
        cycles(1);
        check("t1 busy low after tx_done", 32'(busy[0]), 0);
        check("t1 fifo_rd pulses", 32'(rd_cnt[0]), 1);

        // Back-to-back 0xA5, 0x01 on ch0
        base = rd_cnt[0];
        drive_slot();
        push(0, 8'hA5, 1'b1);
        push(0, 8'h01, 1'b1);
        wait_for(0, 1'b0, 10, r);
        wait_for(0, 1'b1, 80, d1);
        check("t2 frame1 length", 32'(d1 - r), 32'(4 * nb0));
        check("t2 fifo_rd with tx_done", 32'(rd[0]), 1);
        wait_for(0, 1'b1, 80, d2);
        check("t2 frame2 length", 32'(d2 - d1), 32'(4 * nb0));
        check("t2 no pop at last tx_done", 32'(rd[0]), 0);
        check("t2 busy held at boundary", 32'(busy[0]), 1);
        cycles(1);
        check("t2 busy low after frames", 32'(busy[0]), 0);
        check("t2 fifo_rd pulses", 32'(rd_cnt[0] - base), 2);
        gap = (start_log.size() >= 2) ?
              start_log[start_log.size() - 1] - start_log[start_log.size() - 2] : -1;
        check("t2 start-to-start spacing", 32'(gap), 32'(4 * nb0));

        // Two stop bits, odd parity: 0xA5 on ch1
        drive_slot();
        push(1, 8'hA5, 1'b1);
        wait_for(1, 1'b0, 10, r);
        wait_for(1, 1'b1, 80, d1);
        check("t3 frame length", 32'(d1 - r), 32'(4 * nb1));
        cycles(1);
        check("t3 busy low after tx_done", 32'(busy[1]), 0);
        check("t3 fifo_rd pulses", 32'(rd_cnt[1]), 1);

        // tx_en low holds off the frame; dropping it mid-frame stops after that frame
        drive_slot();
        tx_en = 1'b0;
        push(0, 8'h5A, 1'b1);
        push(0, 8'h66, 1'b0);
        base = rd_cnt[0];
        seen_rd = 1'b0; seen_low = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CPU_Clk);
            if (rd[0] !== 1'b0) seen_rd = 1'b1;
            if (tx[0] !== 1'b1) seen_low = 1'b1;
        end
        check("t4 no pop while disabled", 32'(seen_rd), 0);
        check("t4 Tx idle while disabled", 32'(seen_low), 0);
        drive_slot();
        tx_en = 1'b1;
        wait_for(0, 1'b0, 5, r);
        cycles(10);
        drive_slot();
        tx_en = 1'b0;
        wait_for(0, 1'b1, 80, d1);
        check("t4 frame completes", 32'(d1 - r), 32'(4 * nb0));
        cycles(20);
        check("t4 single pop", 32'(rd_cnt[0] - base), 1);
        check("t4 Tx idle after frame", 32'(tx[0]), 1);
        check("t4 busy low after frame", 32'(busy[0]), 0);
        drive_slot();
        fq0.delete();

        // Reset in the middle of a 0x3C frame
        mon_en = 1'b0;
        drive_slot();
        push(0, 8'h3C, 1'b0);
        tx_en = 1'b1;
        wait_for(0, 1'b0, 10, r);
        cycles(17);
        check("t5 busy before reset", 32'(busy[0]), 1);
        Reset_n = 1'b0;
        #1;
        check("t5 async Tx high", 32'(tx[0]), 1);
        check("t5 async busy low", 32'(busy[0]), 0);
        cycles(3);
        drive_slot();
        Reset_n = 1'b1;
        seen_rd = 1'b0; seen_low = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CPU_Clk);
            if (rd[0] !== 1'b0) seen_rd = 1'b1;
            if (tx[0] !== 1'b1) seen_low = 1'b1;
        end
        check("t5 no re-pop after reset", 32'(seen_rd), 0);
        check("t5 Tx idle after reset", 32'(seen_low), 0);
        mon_en = 1'b1;

        // Empty FIFOs with tx_en high: nothing happens
        seen_rd = 1'b0; seen_low = 1'b0; seen_busy = 1'b0; seen_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CPU_Clk);
            if (rd !== 2'b00) seen_rd = 1'b1;
            if (tx !== 2'b11) seen_low = 1'b1;
            if (busy !== 2'b00) seen_busy = 1'b1;
            if (done !== 2'b00) seen_done = 1'b1;
        end
        check("t6 fifo_rd stays 0", 32'(seen_rd), 0);
        check("t6 Tx stays 1", 32'(seen_low), 0);
        check("t6 busy stays 0", 32'(seen_busy), 0);
        check("t6 tx_done stays 0", 32'(seen_done), 0);

        check("ch0 all expected frames seen", 32'(exp0.size()), 0);
        check("ch1 all expected frames seen", 32'(exp1.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/usart_tx.md
# usart_tx

Serial transmitter of the USART that drains the 8-bit TX byte FIFO (show-ahead: read data is valid whenever `empty` is low) and shifts each byte onto the `Tx` line as an asynchronous frame. It has one start bit, 8 data bits LSB first, an optional parity bit and 1 or 2 stop bits. It sits between the CPU-written TX FIFO and the pad, issuing one-cycle FIFO read strobes and running frames back to back while data is available.

## Interface
Parameters:
- `BAUD_DIV`, 868 — CPU_Clk cycles per serial bit; legal range 2..65535.
- `STOP_BITS`, 1 — number of stop bits; legal values 1 or 2.
- `PARITY_ODD`, 0 — parity sense when parity is compiled in: 0 = even, 1 = odd.

Ports (one clock; reset is asynchronous and active-low):
- `CPU_Clk`  input  1  system clock; all state changes on its rising edge.
- `Reset_n`  input  1  asynchronous active-low reset.
- `tx_en`  input  1  transmit enable; gates the start of new frames only.
- `fifo_data`  input  8  FIFO head byte; valid when `fifo_empty` = 0.
- `fifo_empty`  input  1  FIFO empty flag.
- `fifo_rd`  output  1  FIFO pop strobe, combinational, one cycle per byte.
- `Tx`  output  1  serial line; idles high.
- `busy`  output  1  high while a frame is in progress (state ≠ IDLE).
- `tx_done`  output  1  one-cycle pulse in the last clock of the final stop bit.

## Operation
- States:
  - IDLE
  - START
  - DATA
  - PARITY: present only with `USART_TX_PARITY_EN`.
  - STOP
- Baud counter:
  - Width $clog2(BAUD_DIV).
  - Counts 0..BAUD_DIV-1, then wraps to 0.
  - `bit_tick` = (count == BAUD_DIV-1).
  - Cleared on every frame load.
- Bit counter:
  - 3 bits, indexes data bits 0..7.
  - Also counts stop bits when STOP_BITS = 2.
- Load condition:
  - LOAD = `tx_en` & !`fifo_empty` & (state == IDLE | (state == STOP & last stop bit & `bit_tick`)).
  - `fifo_rd` = LOAD.
  - On the LOAD edge: the shift register captures `fifo_data`, parity is computed, and the state becomes START.
- Transitions, each bit lasting exactly BAUD_DIV cycles:
  - START → DATA.
  - DATA after bit 7 → PARITY, or STOP when parity is compiled out.
  - PARITY → STOP.
  - STOP after the last stop bit → START if LOAD, otherwise IDLE.
- `Tx` levels by state:
  - IDLE: 1.
  - START: 0.
  - DATA: shift register bit 0; the register shifts right on `bit_tick`.
  - PARITY: parity bit.
  - STOP: 1.
- `Tx` is registered (glitch-free).
- Frame length = BAUD_DIV × (1 + 8 + P + STOP_BITS) cycles, where P = 1 with parity compiled in and 0 without.
- `tx_en` dropped mid-frame: the current frame completes normally; no further LOAD.
- `fifo_empty` rising mid-frame: no effect on the current frame.
- `fifo_rd` is never asserted while `fifo_empty` = 1.

## Timing
- Reset values: state IDLE, `Tx` = 1, `busy` = 0, `tx_done` = 0, `fifo_rd` = 0, all counters 0.
- Reset mid-frame: `Tx` returns high immediately (asynchronous). The partially sent byte is discarded and not re-popped.
- Latency: if LOAD is true before rising edge k, `Tx` = 0 and `busy` = 1 from edge k.
- Back-to-back frames:
  - The next start bit begins on the edge immediately after the last stop-bit cycle.
  - There is zero idle gap.
  - `busy` stays high across the boundary.
- `tx_done` and back-to-back `fifo_rd` coincide in the same cycle.
- `busy` falls on the edge after the `tx_done` cycle when no LOAD occurs.

## Configuration
- `USART_TX_PARITY_EN` defined:
  - The PARITY state is present.
  - Parity bit = ^data when PARITY_ODD = 0, ~^data when PARITY_ODD = 1.
  - Frame is 10 + STOP_BITS bits.
- `USART_TX_PARITY_EN` undefined:
  - No PARITY state and no parity logic.
  - Frame is 9 + STOP_BITS bits.
  - `PARITY_ODD` is ignored.

## Test plan
- BAUD_DIV = 4, no parity, STOP_BITS = 1; FIFO holds 0xA5 → one `fifo_rd` pulse; `Tx` sampled every 4 cycles = 0,1,0,1,0,0,1,0,1,1; `tx_done` at cycle 40; `busy` low at cycle 41.
- Parity compiled in, PARITY_ODD = 0, send 0xA5 then 0x01 → parity bits 0 then 1; frames of 44 cycles each, back to back with no idle gap; `fifo_rd` asserted exactly twice.
- Parity compiled in, PARITY_ODD = 1, send 0xA5 → parity bit 1; STOP_BITS = 2 → `Tx` high for 8 cycles after parity; total frame 48 cycles.
- `tx_en` = 0 with FIFO non-empty → `fifo_rd` never asserted and `Tx` stays 1. Then raise `tx_en` and drop it at cycle 10 of the frame → that frame completes, no second pop.
- `Reset_n` asserted at cycle 17 of a 0x3C frame → `Tx` = 1, `busy` = 0 asynchronously; after release with FIFO empty, `Tx` stays 1 and `fifo_rd` stays 0.
- Empty FIFO throughout, `tx_en` = 1 → `fifo_rd`, `busy` and `tx_done` all remain 0; `Tx` stays 1.
